mfp_uart_srec_loader: RTL

- Sits directly downstream of the UART receiver. Consumes its byte_data / byte_ready character stream.
- Parses Motorola S-record text (S3 data records, S7 termination records).
- Emits 32-bit word writes toward the memory-load path, plus status flags.
- Lets a host download a program image over the serial line without the debugger.

---
 rtl/mfp_uart_srec_loader_pkg.sv | 33 +++
 rtl/mfp_uart_srec_loader_if.sv | 21 ++
 rtl/mfp_srec_hex_digit.sv | 23 ++
 rtl/mfp_uart_srec_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_srec_loader_pkg.sv
// Shared definitions for the UART S-record loader: parser states,
// ASCII character codes and the record byte-count rule.
package mfp_uart_srec_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CHECKSUM,
    ST_SKIP
  } state_t;

  localparam logic [7:0] CHAR_S     = 8'h53;  // 'S'
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;  // '0'
  localparam logic [7:0] CHAR_NINE  = 8'h39;  // '9'

  // Record type characters following 'S'
  localparam logic [7:0] REC_DATA32 = 8'h33;  // '3'
  localparam logic [7:0] REC_TERM32 = 8'h37;  // '7'

  // Byte count covers address, data and checksum. S7 carries only a
  // 4-byte address; S3 carries whole 32-bit words, i.e. N % 4 == 1.
  function automatic logic count_valid(input logic is_term, input logic [7:0] n);
    if (is_term) return (n == 8'd5);
    return (n >= 8'd5) && (n[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/mfp_uart_srec_loader_if.sv
// Character stream in, word writes and status out.
// master: UART/host side driving characters; slave: the loader.
interface mfp_uart_srec_loader_if;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        in_progress;
  logic        format_error;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;

  modport master (
    output char_data, char_ready,
    input  in_progress, format_error, write_enable, write_address, write_data
  );

  modport slave (
    input  char_data, char_ready,
    output in_progress, format_error, write_enable, write_address, write_data
  );
endinterface

// File: rtl/mfp_srec_hex_digit.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble.
module mfp_srec_hex_digit (
  input  logic [7:0] char_code,
  output logic [3:0] value,
  output logic       valid
);

  // Range-decode the character; letters map to 10..15
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    value = 4'h0;
    valid = 1'b0;
    if (char_code >= 8'h30 && char_code <= 8'h39) begin
      value = char_code[3:0];
      valid = 1'b1;
    end else if ((char_code >= 8'h41 && char_code <= 8'h46) ||
                 (char_code >= 8'h61 && char_code <= 8'h66)) begin
      value = char_code[3:0] + 4'd9;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/mfp_uart_srec_loader.sv
// Motorola S-record (S3/S7) loader sitting behind the UART receiver.
// Emits masked, word-aligned 32-bit writes plus in_progress/format_error.
// Optional: define MFP_SREC_CHECKSUM_EN to verify record checksums.
module mfp_uart_srec_loader
  import mfp_uart_srec_loader_pkg::*;
#(
  parameter logic [31:0] address_mask   = 32'h1FFF_FFFF,
  parameter int unsigned timeout_cycles = 50_000_000
) (
  input logic                  clock,
  input logic                  reset_n,
  mfp_uart_srec_loader_if.slave bus
);

  localparam logic [31:0] TIMEOUT_LOAD = 32'(timeout_cycles);

  state_t      state, state_next;
  logic        accept;
  logic [3:0]  nib;
  logic        is_hex;
  logic        is_digit;
  logic        is_term;          // current record is S7
  logic [2:0]  digit_cnt;        // digit index within field (wraps per data word)
  logic [7:0]  count;
  logic [7:0]  count_byte;
  logic [8:0]  data_digits_left;
  logic [31:0] addr;
  logic [31:0] addr_full;
  logic [31:0] word;
  logic [31:0] timer;
  logic        timeout_hit;
  logic        set_error;
  logic        word_done;
  logic        start_progress;
  logic        end_progress;
  logic        checksum_ok;

  mfp_srec_hex_digit u_hex (
    .char_code (bus.char_data),
    .value     (nib),
    .valid     (is_hex)
  );

  assign accept      = bus.char_ready;
  assign is_digit    = (bus.char_data >= CHAR_ZERO) && (bus.char_data <= CHAR_NINE);
  assign count_byte  = {count[3:0], nib};
  assign addr_full   = {addr[27:0], nib};
  assign timeout_hit = (state != ST_IDLE) && !accept && (timer == 32'd1);

`ifdef MFP_SREC_CHECKSUM_EN
  logic [7:0] sum;
  logic [3:0] hi_nib;
  logic [7:0] byte_value;
  assign byte_value  = {hi_nib, nib};
  assign checksum_ok = ((sum + byte_value) == 8'hFF);
`else
  assign checksum_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    else          state <= state_next;
  end

  // Next-state decode, error detection and output event strobes
  always_comb begin
    state_next     = state;
    set_error      = 1'b0;
    word_done      = 1'b0;
    start_progress = 1'b0;
    end_progress   = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.char_data == CHAR_S) state_next = ST_TYPE;
          else if (bus.char_data != CHAR_CR && bus.char_data != CHAR_LF &&
                   bus.char_data != CHAR_SPACE) set_error = 1'b1;
        end
        ST_TYPE: begin
          if (bus.char_data == REC_DATA32 || bus.char_data == REC_TERM32) begin
            state_next = ST_COUNT;
          end else begin
            state_next = ST_SKIP;
            set_error  = !is_digit;
          end
        end
        ST_COUNT: begin
          if (!is_hex) begin
            state_next = ST_SKIP;
            set_error  = 1'b1;
          end else if (digit_cnt == 3'd1) begin
            if (count_valid(is_term, count_byte)) state_next = ST_ADDR;
            else begin
              state_next = ST_SKIP;
              set_error  = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (!is_hex) begin
            state_next = ST_SKIP;
            set_error  = 1'b1;
          end else if (digit_cnt == 3'd7) begin
            if (!is_term && addr_full[1:0] != 2'b00) begin
              state_next = ST_SKIP;
              set_error  = 1'b1;
            end else begin
              start_progress = !is_term;
              state_next = (!is_term && data_digits_left != 9'd0) ? ST_DATA : ST_CHECKSUM;
            end
          end
        end
        ST_DATA: begin
          if (!is_hex) begin
            state_next = ST_SKIP;
            set_error  = 1'b1;
          end else begin
            word_done = (digit_cnt == 3'd7);
            if (data_digits_left == 9'd1) state_next = ST_CHECKSUM;
          end
        end
        ST_CHECKSUM: begin
          if (!is_hex) begin
            state_next = ST_SKIP;
            set_error  = 1'b1;
          end else if (digit_cnt == 3'd1) begin
            state_next   = ST_SKIP;
            set_error    = !checksum_ok;
            end_progress = is_term && checksum_ok;
          end
        end
        ST_SKIP: begin
          if (bus.char_data == CHAR_LF) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
      set_error  = 1'b1;
    end
  end

  // Field accumulators: digit index, count, address, data word, byte budget
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit_cnt        <= 3'd0;
      is_term          <= 1'b0;
      count            <= 8'h00;
      addr             <= 32'h0;
      word             <= 32'h0;
      data_digits_left <= 9'd0;
    end else if (accept) begin
      digit_cnt <= (state_next == state) ? digit_cnt + 3'd1 : 3'd0;
      if (state == ST_TYPE) is_term <= (bus.char_data == REC_TERM32);
      if (is_hex) begin
        unique case (state)
          ST_COUNT: begin
            count <= count_byte;
            if (digit_cnt == 3'd1)
              data_digits_left <= ({1'b0, count_byte} - 9'd5) << 1;
          end
          ST_ADDR: addr <= addr_full;
          ST_DATA: begin
            word             <= {word[27:0], nib};
            data_digits_left <= data_digits_left - 9'd1;
            if (word_done) addr <= addr + 32'd4;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered write port: strobe the cycle after a word completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.write_enable  <= 1'b0;
      bus.write_address <= 32'h0;
      bus.write_data    <= 32'h0;
    end else begin
      bus.write_enable <= word_done;
      if (word_done) begin
        bus.write_address <= addr & address_mask & ~32'h3;
        bus.write_data    <= {word[27:0], nib};
      end
    end
  end

  // Status flags: in_progress tracks the image, format_error is sticky
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.in_progress  <= 1'b0;
      bus.format_error <= 1'b0;
    end else begin
      if (start_progress)    bus.in_progress <= 1'b1;
      else if (end_progress) bus.in_progress <= 1'b0;
      if (set_error) bus.format_error <= 1'b1;
    end
  end

  // Inactivity timer: reload on every character, count down mid-record
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                timer <= 32'h0;
    else if (accept)                             timer <= TIMEOUT_LOAD;
    else if (state != ST_IDLE && timer != 32'h0) timer <= timer - 32'd1;
  end

`ifdef MFP_SREC_CHECKSUM_EN
  // Per-record running sum of count, address and data bytes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum    <= 8'h00;
      hi_nib <= 4'h0;
    end else if (state == ST_IDLE) begin
      sum <= 8'h00;
    end else if (accept && is_hex) begin
      hi_nib <= nib;
      if (digit_cnt[0] && (state == ST_COUNT || state == ST_ADDR || state == ST_DATA))
        sum <= sum + byte_value;
    end
  end
`endif

endmodule
